iter_comparator: RTL
====================

ITER_COMPARATOR -- requirements
Module: iter_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK_W.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  block can accept a request.
REQ-007 SHALL have port i_a  input  WIDTH  operand A.
REQ-008 SHALL have port i_b  input  WIDTH  operand B.
REQ-009 SHALL have port i_op  input  2  00 SLT (signed A<B), 01 SLTU (unsigned A<B), 10 EQ, 11 NE.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port i_ready  input  1  consumer accepts result.
REQ-012 SHALL have port o_result  output  1  comparison result.
REQ-013 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 o_ready SHALL be 1 only in IDLE; accept = i_valid & o_ready at a rising edge.
REQ-016 On accept SHALL register i_a, i_b, i_op, set chunk index to NCHUNK-1 (MSB chunk), go to RUN; later input changes SHALL be ignored.
REQ-017 For SLT, the captured operands' bit WIDTH-1 SHALL be inverted before comparison, reducing signed order to unsigned order.
REQ-018 Each RUN edge SHALL compare one chunk, MSB chunk first; the first chunk with A!=B decides lt = (A chunk < B chunk); later chunks SHALL NOT alter a decided lt.
REQ-019 If all chunks are equal: eq=1, lt=0.
REQ-020 o_result SHALL be lt for SLT/SLTU, eq for EQ, ~eq for NE.
REQ-021 After the edge processing chunk 0, FSM SHALL enter DONE with o_valid=1.
REQ-022 In DONE, o_valid and o_result SHALL stay stable until o_valid & i_ready at an edge, then return to IDLE.
REQ-023 SHALL NOT accept a new request in the same cycle a result is consumed; next accept no earlier than the following edge.
REQ-024 Without early exit, o_valid SHALL rise exactly NCHUNK edges after the accepting edge.
REQ-025 i_valid while not in IDLE SHALL have no effect; i_ready outside DONE SHALL have no effect.
REQ-026 Elaboration SHALL fail if WIDTH % CHUNK_W != 0, CHUNK_W < 1 or WIDTH < 2.

Reset
REQ-027 i_rst_n low SHALL immediately, independent of i_clk, force IDLE, o_valid=0, o_result=0, o_busy=0, o_ready=1 (o_ready may follow deassertion).
REQ-028 Reset asserted in RUN or DONE SHALL discard the operation; no result SHALL be presented afterwards.
REQ-029 First accept SHALL be possible on the first rising edge after i_rst_n deasserts.

Configuration
REQ-030 Macro ITER_CMP_EARLY_EXIT_EN defined: RUN SHALL enter DONE on the edge that processes the first differing chunk; o_valid rises k edges after accept, k = 1-based position of that chunk from MSB; equal operands take NCHUNK edges.
REQ-031 Macro ITER_CMP_EARLY_EXIT_EN undefined: latency SHALL always be NCHUNK edges per REQ-024; results identical in both builds.

Verification (WIDTH=32, CHUNK_W=8)
REQ-032 SLT A=0xFFFFFFFF, B=0x00000001 -> o_result=1; SLTU same operands -> o_result=0.
REQ-033 EQ A=B=0x12345678 -> o_result=1, o_valid 4 edges after accept in both builds; NE same -> 0.
REQ-034 SLTU A=0x01000000, B=0x02000000 -> o_result=1 after 1 edge with ITER_CMP_EARLY_EXIT_EN, 4 edges without.
REQ-035 SLT A=0x80000000, B=0x7FFFFFFF -> o_result=1; i_ready held low 5 cycles -> o_valid=1, o_result stable, o_ready=0, i_valid pulses ignored.
REQ-036 i_rst_n asserted 2 edges into SLTU 0x00000005 vs 0x00000006 -> o_valid=0, o_busy=0 at once; no stale result after release; next request completes correctly.

Source files
------------

// File: rtl/iter_comparator.sv
// -----------------------------------------------------------------------------
// iter_comparator
//   Multi-cycle comparator. A request (i_a, i_b, i_op) is captured in IDLE and
//   compared CHUNK_W bits per cycle, most-significant chunk first. The result
//   is held on o_valid/o_result until the consumer takes it with i_ready.
//
//   Operations (i_op): 00 SLT signed A<B, 01 SLTU unsigned A<B, 10 EQ, 11 NE.
//
//   Optional build macro:
//     ITER_CMP_EARLY_EXIT_EN - finish on the first differing chunk instead of
//                              always walking all NCHUNK chunks. Results are
//                              identical; only latency differs.
//
//   Ports:
//     i_clk     rising-edge clock
//     i_rst_n   asynchronous active-low reset
//     i_valid   request valid          o_ready   request accepted when high
//     i_a, i_b  operands (WIDTH)       i_op      operation select
//     o_valid   result valid           i_ready   consumer takes result
//     o_result  comparison result      o_busy    high whenever not IDLE
// -----------------------------------------------------------------------------
module iter_comparator #(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_result,
  output logic             o_busy
);

  localparam int SAFE_CW = (CHUNK_W < 1) ? 1 : CHUNK_W;
  localparam int NCHUNK  = WIDTH / SAFE_CW;
  localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

`ifdef ITER_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  if ((CHUNK_W < 1) || (WIDTH < 2) || ((WIDTH % SAFE_CW) != 0)) begin : g_bad_cfg
    $error("iter_comparator: WIDTH must be >= 2 and a multiple of CHUNK_W >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLT  = 2'b00,
    OP_SLTU = 2'b01,
    OP_EQ   = 2'b10,
    OP_NE   = 2'b11
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               lt_q, eq_q;
  logic               valid_q, result_q;

  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [CHUNK_W-1:0] a_c, b_c;
  int unsigned        base;
  logic               chunk_ne;
  logic               lt_d, eq_d, result_d, finish;

  // Current chunk, selected by shifting rather than an indexed part-select.
  always_comb begin
    base = int'(idx_q) * CHUNK_W;
    a_sh = a_q >> base;
    b_sh = b_q >> base;
    a_c  = a_sh[CHUNK_W-1:0];
    b_c  = b_sh[CHUNK_W-1:0];
  end

  // eq_q doubles as "still undecided": once a chunk differs, lt is frozen.
  always_comb begin
    chunk_ne = (a_c != b_c);
    lt_d     = lt_q;
    eq_d     = eq_q;
    if (eq_q && chunk_ne) begin
      lt_d = (a_c < b_c);
      eq_d = 1'b0;
    end
    finish = (idx_q == '0) || (EARLY_EXIT && chunk_ne);
  end

  always_comb begin
    result_d = 1'b0;
    case (op_q)
      OP_SLT, OP_SLTU: result_d = lt_d;
      OP_EQ:           result_d = eq_d;
      OP_NE:           result_d = ~eq_d;
      default:         result_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_SLT;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            // Flipping the sign bit of both operands maps signed order onto
            // unsigned order, so the chunk walk is the same for SLT and SLTU.
            a_q     <= (op_e'(i_op) == OP_SLT) ? (i_a ^ {1'b1, {(WIDTH-1){1'b0}}}) : i_a;
            b_q     <= (op_e'(i_op) == OP_SLT) ? (i_b ^ {1'b1, {(WIDTH-1){1'b0}}}) : i_b;
            op_q    <= op_e'(i_op);
            idx_q   <= LAST_IDX;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          lt_q  <= lt_d;
          eq_q  <= eq_d;
          idx_q <= idx_q - IDX_W'(1);
          if (finish) begin
            valid_q  <= 1'b1;
            result_q <= result_d;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q != IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
